// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// uart_rx_8n1 : 16x-oversampled UART receiver, one-entry ready/valid output.
// Optional even parity when UART_RX_PARITY_EN is defined.    Rev 1.0
// ============================================================================
module uart_rx_8n1 #(
  parameter int CLK_FREQ_HZ = 32_250_000,
  parameter int BAUD        = 115_200,
  parameter int OS_DIV      = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam int OS_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic            rx_meta;
  logic            rx_s;
  logic [2:0]      state;
  logic [OS_W-1:0] os_cnt;
  logic [3:0]      sub_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            deliver;
  logic            tick;
  logic            mid_tick;
  logic            last_tick;
  logic            byte_ok;

  assign tick      = (os_cnt == OS_LAST);
  assign mid_tick  = tick && (sub_cnt == 4'd7);
  assign last_tick = tick && (sub_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign byte_ok = ~^{shift, parity_bit};
`else
  assign byte_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      os_cnt       <= '0;
      sub_cnt      <= 4'd0;
      bit_idx      <= 3'd0;
      shift        <= 8'd0;
      deliver      <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      deliver      <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      // Tick counter idles at zero so the first tick is phase-aligned to the edge
      if (state == S_IDLE || tick) os_cnt <= '0;
      else                         os_cnt <= os_cnt + 1'b1;
      if (state != S_IDLE && tick) sub_cnt <= sub_cnt + 4'd1;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            sub_cnt <= 4'd0;
          end
        end
        S_START: begin
          if (mid_tick) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              sub_cnt <= 4'd0;
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_tick) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (last_tick) begin
            parity_bit <= rx_s;
            state      <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid-stop lets an early next start edge be caught
          if (last_tick) begin
            if (rx_s) begin
              deliver      <= byte_ok;
`ifdef UART_RX_PARITY_EN
              parity_err_o <= ~byte_ok;
`endif
              state        <= S_IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o    <= 8'd0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        // A byte drained in the same cycle frees the slot for the new one
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver stage inside `top`. It sits directly downstream of the board-level RX pin and the PLL-generated fabric clock, and directly upstream of the ALU command parser.
- Synchronises the asynchronous `rx_i` line, detects and validates start bits with a 16x oversampling tick, and shifts in 8 data bits LSB-first.
- Checks the stop bit and presents each byte on a one-entry ready/valid holding register, with framing-error and overrun pulses.

Parameters:
- CLK_FREQ_HZ, 32_250_000, fabric clock frequency in Hz (PLL output).
- BAUD, 115_200, line rate in bits/s.
- OS_DIV, (CLK_FREQ_HZ + BAUD*8)/(BAUD*16), clocks per oversample tick; rounded; must be >= 1. Default evaluates to 17.

Ports:
- clk  in  1  fabric clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  raw serial line, idle high, asynchronous to clk.
- data_o  out  8  received byte, valid while valid_o=1.
- valid_o  out  1  byte available.
- ready_i  in  1  consumer accepts byte when valid_o & ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  out  1  one-cycle pulse: byte completed while holding register full and not drained that cycle.

Behaviour:
- Reset (async assert, sync release):
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
  - Both synchroniser flops=1; state=IDLE; tick and bit counters=0.
  - Reset mid-byte discards the partial byte.
- Synchroniser: 2 flops; rx_s is the second-flop output. All decisions use rx_s only.
- Tick generator:
  - Counter 0..OS_DIV-1 produces a one-cycle `tick` at the terminal count.
  - The counter is cleared on the IDLE->START transition, so ticks are phase-aligned to the detected edge.
- FSM:
  - IDLE: rx_s=0 -> START; clear tick counter and sub-tick counter (0..15).
  - START: on the 8th tick (mid start bit) sample rx_s. If 1, treat as a glitch -> IDLE with no output. If 0, clear sub-tick counter -> DATA with bit index 0.
  - DATA: every 16th tick sample rx_s into shift[bit] (LSB first). After bit 7 -> STOP.
  - STOP: on the 16th tick sample rx_s.
    - If 1: deliver byte, -> IDLE.
    - If 0: frame_err_o=1 for one cycle, discard byte, -> BREAK.
  - BREAK: wait until rx_s=1, then -> IDLE. A held-low line (break) never produces a byte.
- Returning to IDLE at mid-stop allows a next start edge arriving half a bit early.
- Delivery (cycle after the stop sample):
  - valid_o=0: data_o<=shift, valid_o<=1.
  - valid_o=1 and ready_i=1 in the same cycle: data_o<=new byte, valid_o stays 1; no overrun.
  - valid_o=1 and ready_i=0: new byte dropped, data_o and valid_o unchanged, overrun_o=1 for one cycle.
- Handshake: valid_o & ready_i with no delivery -> valid_o<=0 next cycle. data_o holds its value until the next delivery.
- Latency: valid_o rises 2 (sync) + 8*OS_DIV + 8*16*OS_DIV + 16*OS_DIV + 1 cycles after the rx_i falling edge, ±1 synchroniser cycle. This is 9.5 bit periods plus a constant.
- ready_i is ignored while valid_o=0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; samples one bit on the 16th tick.
  - Even parity required: XOR(data, parity)=0.
  - Adds output port parity_err_o (1 bit, reset 0): a one-cycle pulse on mismatch, asserted with the stop-sample cycle timing.
  - On a parity error the byte is discarded and STOP handling proceeds normally. A framing error takes precedence and suppresses parity_err_o.
- Undefined: 8N1 only; no parity_err_o port.

Test Plan (CLK_FREQ_HZ=7_372_800, BAUD=115_200 -> OS_DIV=4, bit period 64 cycles):
1. Send 0xA5 8N1 with ready_i=1 -> data_o=0xA5 and valid_o high exactly one cycle (~610 cycles after start edge); frame_err_o and overrun_o stay 0.
2. Drive rx_i low for 20 cycles then high -> no valid_o, no frame_err_o; then send 0x5A -> received 0x5A.
3. Send 0x3C with stop bit 0, then hold low 300 cycles, then idle and send 0x01 -> one frame_err_o pulse, no valid for 0x3C, no spurious byte during the low hold, data_o=0x01 valid.
4. ready_i=0; send 0x11 then 0x22 back-to-back -> valid_o=1 with data_o=0x11; overrun_o pulses once at 0x22 completion; data_o remains 0x11. Raise ready_i -> valid_o drops next cycle.
5. Assert rst_n=0 during bit 4 of 0xFF for 3 cycles, release, idle 100 cycles, send 0x7E -> outputs 0 during reset, then exactly one byte 0x7E.
6. With UART_RX_PARITY_EN: send 0x07 with parity 1 -> accepted, data_o=0x07. Send 0x07 with parity 0 -> parity_err_o pulse, no valid_o.
